spi_slave_m: RTL and testbench



---
 rtl/spi_slave_m.sv | 161 ++++++++++++++++
 tb/tb_spi_slave_m.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_m.sv
// SPI mode-0 slave: SCK/CS/MOSI oversampled in the CLK domain, MSB-first 8-bit bytes,
// one-deep transmit holding register with ready/load handshake.
module spi_slave_m #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       CS,
   input  logic       SCK,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [7:0] TX_DATA,
   input  logic       TX_LOAD,
   output logic       TX_READY,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   output logic       UNDERRUN,
   output logic       FRAME_ERR
);

   typedef enum logic {S_IDLE, S_ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_cs_d;
   logic                   r_sck_d;

   state_t     r_state;
   logic [2:0] r_bitcnt;
   logic [6:0] r_rx_shift;
   logic [7:0] r_tx_shift;
   logic [7:0] r_hold;
   logic       r_tx_ready;
   logic       r_byte_done;
   logic       r_miso;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;
   logic       r_underrun;
   logic       r_frame_err;

   logic       w_cs;
   logic       w_sck;
   logic       w_mosi;
   logic       w_cs_fall;
   logic       w_cs_rise;
   logic       w_sck_rise;
   logic       w_sck_fall;
   logic [2:0] w_cnt_inc;
   logic [2:0] w_cnt_after;
   logic       w_reload;
   logic       w_consume;
   logic       w_load_ok;
   logic [7:0] w_hold_val;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cs_sync   <= '1;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_d      <= 1'b1;
         r_sck_d     <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
         r_cs_d      <= w_cs;
         r_sck_d     <= w_sck;
      end
   end

   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_sck       = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs_fall   = r_cs_d & ~w_cs;
   assign w_cs_rise   = ~r_cs_d & w_cs;
   assign w_sck_rise  = ~r_sck_d & w_sck;
   assign w_sck_fall  = r_sck_d & ~w_sck;
   assign w_cnt_inc   = r_bitcnt + 3'd1;
   assign w_cnt_after = w_sck_rise ? w_cnt_inc : r_bitcnt;
   // A byte boundary reload is suppressed when the frame is ending in the same cycle.
   assign w_reload    = (r_state == S_ACTIVE) & w_sck_fall & (r_bitcnt == 3'd0)
                        & r_byte_done & ~w_cs_rise;
   assign w_consume   = ((r_state == S_IDLE) & w_cs_fall) | w_reload;
   assign w_load_ok   = TX_LOAD & r_tx_ready;
   assign w_hold_val  = r_tx_ready ? DEFAULT_TX : r_hold;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_bitcnt    <= 3'd0;
         r_rx_shift  <= 7'd0;
         r_tx_shift  <= DEFAULT_TX;
         r_hold      <= 8'd0;
         r_tx_ready  <= 1'b1;
         r_byte_done <= 1'b0;
         r_miso      <= 1'b0;
         r_rx_data   <= 8'd0;
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_valid  <= 1'b0;
         r_underrun  <= 1'b0;
         r_frame_err <= 1'b0;
         r_miso      <= ~w_cs & r_tx_shift[7];

         // Consumption is evaluated first; a full register keeps TX_READY low so a
         // simultaneous load cannot overwrite it.
         if (w_consume) begin
            if (r_tx_ready) r_underrun <= 1'b1;
            else            r_tx_ready <= 1'b1;
         end
         if (w_load_ok) begin
            r_hold     <= TX_DATA;
            r_tx_ready <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               r_tx_shift <= w_hold_val;
               r_bitcnt   <= 3'd0;
               if (w_cs_fall) begin
                  r_state     <= S_ACTIVE;
                  r_byte_done <= 1'b0;
               end
            end
            S_ACTIVE: begin
               if (w_sck_rise) begin
                  r_rx_shift <= {r_rx_shift[5:0], w_mosi};
                  r_bitcnt   <= w_cnt_inc;
                  if (r_bitcnt == 3'd7) begin
                     r_rx_data   <= {r_rx_shift, w_mosi};
                     r_rx_valid  <= 1'b1;
                     r_byte_done <= 1'b1;
                  end
               end
               if (w_sck_fall) begin
                  if (r_bitcnt != 3'd0) r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                  else if (w_reload)    r_tx_shift <= w_hold_val;
               end
               if (w_cs_rise) begin
                  r_state  <= S_IDLE;
                  r_bitcnt <= 3'd0;
                  if (w_cnt_after != 3'd0) r_frame_err <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign MISO      = r_miso;
   assign TX_READY  = r_tx_ready;
   assign RX_DATA   = r_rx_data;
   assign RX_VALID  = r_rx_valid;
   assign UNDERRUN  = r_underrun;
   assign FRAME_ERR = r_frame_err;

endmodule

// File: tb/tb_spi_slave_m.sv
// Scoreboard bench for spi_slave_m: a bit-banged mode-0 master drives bytes while
// monitor processes compare RX_VALID bytes and master-received bytes against queues.
module tb_spi_slave_m;

   logic       CLK = 1'b0;
   logic       RST, CS, SCK, MOSI, TX_LOAD;
   logic [7:0] TX_DATA;
   logic       MISO, TX_READY, RX_VALID, UNDERRUN, FRAME_ERR;
   logic [7:0] RX_DATA;

   spi_slave_m #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
      .CLK(CLK), .RST(RST), .CS(CS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
      .TX_DATA(TX_DATA), .TX_LOAD(TX_LOAD), .TX_READY(TX_READY),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .UNDERRUN(UNDERRUN), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int n_rx = 0, n_under = 0, n_ferr = 0;
   logic [7:0] q_rx_exp[$];
   logic [7:0] q_miso_exp[$];
   logic [7:0] q_miso_got[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s value=%0h", name, act);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Monitor: RX strobes, pulse counters and master-side received bytes.
   always @(negedge CLK) begin
      if (RST !== 1'b1) begin
         if (RX_VALID === 1'b1) begin
            n_rx++;
            if (q_rx_exp.size() == 0) fail_now("rx_unexpected");
            else check("rx_data", 32'(RX_DATA), 32'(q_rx_exp.pop_front()));
         end
         if (UNDERRUN === 1'b1)  n_under++;
         if (FRAME_ERR === 1'b1) n_ferr++;
      end
      if (q_miso_got.size() > 0) begin
         if (q_miso_exp.size() == 0) fail_now("miso_unexpected");
         else check("miso_byte", 32'(q_miso_got.pop_front()), 32'(q_miso_exp.pop_front()));
      end
   end

   // Mode-0 master, SCK = CLK/8.
   task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         MOSI = b[i];
         wclk(4);
         SCK  = 1'b1;
         r[i] = MISO;
         wclk(4);
         SCK  = 1'b0;
      end
   endtask

   task automatic xfer(input logic [7:0] b, input logic [7:0] miso_exp);
      logic [7:0] r;
      q_rx_exp.push_back(b);
      q_miso_exp.push_back(miso_exp);
      spi_bits(b, 8, r);
      q_miso_got.push_back(r);
   endtask

   task automatic cs_low();
      CS = 1'b0;
      wclk(8);
   endtask

   task automatic cs_high();
      wclk(4);
      CS = 1'b1;
      wclk(12);
   endtask

   task automatic produce(input logic [7:0] d);
      int n = 0;
      while (TX_READY !== 1'b1 && n < 3000) begin
         wclk(1);
         n++;
      end
      if (n >= 3000) fail_now("producer_timeout");
      else begin
         TX_DATA = d;
         TX_LOAD = 1'b1;
         wclk(1);
         TX_LOAD = 1'b0;
         wclk(1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      bad++;
      total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int u0, f0, r0;
      logic [7:0] dummy;
      RST = 1'b1; CS = 1'b1; SCK = 1'b0; MOSI = 1'b0; TX_LOAD = 1'b0; TX_DATA = 8'h00;
      wclk(3);
      check("rst_miso", 32'(MISO), 32'd0);
      check("rst_tx_ready", 32'(TX_READY), 32'd1);
      check("rst_rx_data", 32'(RX_DATA), 32'd0);
      check("rst_pulses", 32'({RX_VALID, UNDERRUN, FRAME_ERR}), 32'd0);
      RST = 1'b0;
      wclk(4);

      // 1: preloaded A5, receive 3C; end-of-byte reload finds holding empty.
      u0 = n_under;
      produce(8'hA5);
      check("t1_ready_loaded", 32'(TX_READY), 32'd0);
      cs_low();
      check("t1_ready_after_csfall", 32'(TX_READY), 32'd1);
      xfer(8'h3C, 8'hA5);
      cs_high();
      check("t1_underruns", 32'(n_under - u0), 32'd1);

      // 2: no load -> DEFAULT_TX, underrun at CS fall and at byte end.
      u0 = n_under;
      cs_low();
      xfer(8'h00, 8'hFF);
      cs_high();
      check("t2_underruns", 32'(n_under - u0), 32'd2);

      // 3: three bytes under one CS with producer refilling on TX_READY.
      u0 = n_under;
      produce(8'h81);
      fork
         begin
            cs_low();
            xfer(8'h11, 8'h81);
            xfer(8'h22, 8'h42);
            xfer(8'h33, 8'hC3);
            cs_high();
         end
         begin
            produce(8'h42);
            produce(8'hC3);
         end
      join
      check("t3_underruns", 32'(n_under - u0), 32'd1);

      // 4: CS rises after 5 bits -> FRAME_ERR, RX_DATA kept; then full 5A.
      f0 = n_ferr; r0 = n_rx;
      cs_low();
      spi_bits(8'hB6, 5, dummy);
      cs_high();
      check("t4_frame_err", 32'(n_ferr - f0), 32'd1);
      check("t4_no_rx", 32'(n_rx - r0), 32'd0);
      check("t4_rx_kept", 32'(RX_DATA), 32'h33);
      cs_low();
      xfer(8'h5A, 8'hFF);
      cs_high();

      // 5: reset after bit 3, then a clean E7 transfer.
      cs_low();
      spi_bits(8'hE7, 3, dummy);
      RST = 1'b1;
      wclk(1);
      RST = 1'b0;
      check("t5_miso", 32'(MISO), 32'd0);
      check("t5_tx_ready", 32'(TX_READY), 32'd1);
      check("t5_rx_data", 32'(RX_DATA), 32'd0);
      check("t5_pulses", 32'({RX_VALID, UNDERRUN, FRAME_ERR}), 32'd0);
      f0 = n_ferr; r0 = n_rx;
      wclk(4);
      CS = 1'b1;
      wclk(12);
      check("t5_no_frame_err", 32'(n_ferr - f0), 32'd0);
      check("t5_no_rx", 32'(n_rx - r0), 32'd0);
      cs_low();
      xfer(8'hE7, 8'hFF);
      cs_high();
      check("t5_rx_final", 32'(RX_DATA), 32'hE7);

      // 6: load while not ready is ignored.
      produce(8'h12);
      TX_DATA = 8'h99;
      TX_LOAD = 1'b1;
      wclk(1);
      TX_LOAD = 1'b0;
      wclk(4);
      cs_low();
      xfer(8'h6B, 8'h12);
      cs_high();

      wclk(20);
      check("rx_queue_drained", 32'(q_rx_exp.size()), 32'd0);
      check("miso_queue_drained", 32'(q_miso_exp.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
